adc_multich_acq: RTL

//  Parametrised multi-channel successor to the single-channel ADC reader. Drives shared CNV/SCK to
//  N_CH SPI ADCs with one MISO each and shifts all channels in parallel. Runs single-shot or

---
 rtl/adc_acq_pkg.sv | 25 ++
 rtl/adc_acq_fifo.sv | 59 +++++
 rtl/adc_multich_acq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_acq_pkg.sv
// adc_acq_pkg: shared types and sizing helpers for the multi-channel ADC acquisition block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package adc_acq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_SHIFT = 2'd2,
    S_PUSH  = 2'd3
  } acq_state_t;

  // Channel index width, never narrower than one bit so a single-channel build still has a port.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Shortest CNV-to-CNV spacing: one whole frame (CONV, SHIFT, PUSH) plus the IDLE decision cycle.
  function automatic int min_period(input int conv_cyc, input int data_width, input int n_ch);
    return conv_cyc + 2 * data_width + n_ch + 1;
  endfunction

  localparam int PERIOD_W = 32;

endpackage

// File: rtl/adc_acq_fifo.sv
// adc_acq_fifo: synchronous FIFO with occupancy count and a flush input.
// Latency: a write is visible on o_rd_dat/o_rd_vld the cycle after it is accepted.
// Backpressure: writes while full and reads while empty are ignored; i_clr beats both.
module adc_acq_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 64
) (
  input  logic                       clk_adc,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_wr_vld,
  input  logic [W-1:0]               i_wr_dat,
  input  logic                       i_rd_rdy,
  output logic [W-1:0]               o_rd_dat,
  output logic                       o_rd_vld,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_wr_vld && (r_level != LW'(DEPTH));
  assign w_pop  = i_rd_rdy && (r_level != '0);

  // Pointer and occupancy bookkeeping; a flush resets everything regardless of traffic.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Storage array; contents need no reset because o_rd_vld qualifies them.
  always_ff @(posedge clk_adc) begin
    if (w_push && !i_clr) r_mem[r_wptr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[r_rptr];
  assign o_rd_vld = (r_level != '0);
  assign o_level  = r_level;

endmodule

// File: rtl/adc_multich_acq.sv
// adc_multich_acq: shared CNV/SCK for N_CH SPI ADCs, parallel shift-in, {channel, sample} stream out.
// Latency: CONV_CYC + 2*DATA_WIDTH + 1 cycles from go to first FIFO write, m_valid_o one cycle later.
// Backpressure: m_valid_o/m_ready_i; a frame that does not fit is dropped whole and sets overflow_o.
// Build option: define ADC_AVG_EN to emit one word per channel averaged over 2^AVG_LOG2 frames.
module adc_multich_acq
  import adc_acq_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CONV_CYC   = 40,
  parameter int FIFO_DEPTH = 64,
  parameter int AVG_LOG2   = 2
) (
  input  logic                          clk_adc,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          mode_i,
  input  logic                          trig_i,
  input  logic [PERIOD_W-1:0]           period_i,
  input  logic                          clear_i,
  output logic                          adc_cnv_o,
  output logic                          adc_sck_o,
  input  logic [N_CH-1:0]               adc_miso_i,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic [ch_width(N_CH)-1:0]     m_ch_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int CH_W       = ch_width(N_CH);
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int FW         = CH_W + DATA_WIDTH;
  localparam int CNT_W      = 16;
  localparam int MIN_PERIOD = min_period(CONV_CYC, DATA_WIDTH, N_CH);

  if (N_CH < 1 || N_CH > 16 || FIFO_DEPTH < N_CH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DATA_WIDTH < 2 || CONV_CYC < 1 || AVG_LOG2 < 0) begin : g_bad_cfg
    $error("adc_multich_acq: illegal parameter set");
  end

  acq_state_t                        r_state;
  acq_state_t                        w_state_nxt;
  logic [CNT_W-1:0]                  r_cnt;
  logic                              r_trig_s1, r_trig_s2, r_trig_s3;
  logic                              w_trig_edge;
  logic [PERIOD_W-1:0]               r_per_cnt;
  logic [PERIOD_W-1:0]               w_per_eff;
  logic                              w_go;
  logic                              w_sck;
  logic                              w_shift_done;
  logic                              w_push_last;
  logic [N_CH-1:0][DATA_WIDTH-1:0]   r_sh;
  logic                              r_drop;
  logic                              r_out_frm;
  logic                              w_out_frm;
  logic                              w_admit;
  logic                              r_ovf;
  logic [CH_W-1:0]                   w_ch;
  logic [DATA_WIDTH-1:0]             w_word;
  logic                              w_wr;
  logic [FW-1:0]                     w_fifo_dat;
  logic                              w_fifo_vld;
  logic [LW-1:0]                     w_level;

  assign w_trig_edge = r_trig_s2 && !r_trig_s3;
  assign w_per_eff   = (period_i < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period_i;
  assign w_go        = enable_i && (mode_i ? (r_per_cnt == '0) : w_trig_edge);
  assign w_ch        = r_cnt[CH_W-1:0];
  assign w_admit     = (w_level <= LW'(FIFO_DEPTH - N_CH));

  // Trigger synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_s3 <= 1'b0;
    end else begin
      r_trig_s1 <= trig_i;
      r_trig_s2 <= r_trig_s1;
      r_trig_s3 <= r_trig_s2;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and pin decode; pins come straight off state flops so reset drops them at once.
  always_comb begin
    w_state_nxt  = r_state;
    adc_cnv_o    = 1'b0;
    w_sck        = 1'b0;
    busy_o       = 1'b1;
    w_shift_done = 1'b0;
    w_push_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_go) w_state_nxt = S_CONV;
      end
      S_CONV: begin
        adc_cnv_o = 1'b1;
        if (r_cnt == CNT_W'(CONV_CYC - 1)) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_sck = ~r_cnt[0];
        if (r_cnt == CNT_W'(2 * DATA_WIDTH - 1)) begin
          w_state_nxt  = S_PUSH;
          w_shift_done = 1'b1;
        end
      end
      S_PUSH: begin
        if (r_cnt == CNT_W'(N_CH - 1)) begin
          w_state_nxt = S_IDLE;
          w_push_last = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign adc_sck_o = w_sck;

  // Per-state cycle counter, restarted on every state change; doubles as the push channel index.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (r_state == S_IDLE || w_state_nxt != r_state) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  // Period counter: reloaded when a frame launches, then counts down to zero and waits.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) r_per_cnt <= '0;
    else if (r_state == S_IDLE && w_go) r_per_cnt <= w_per_eff - 1'b1;
    else if (r_per_cnt != '0) r_per_cnt <= r_per_cnt - 1'b1;
  end

  // Shift every channel in parallel on the cycles where SCK is about to fall.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) r_sh <= '0;
    else if (w_sck) begin
      for (int k = 0; k < N_CH; k++) r_sh[k] <= {r_sh[k][DATA_WIDTH-2:0], adc_miso_i[k]};
    end
  end

`ifdef ADC_AVG_EN
  localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
  localparam int FRM_W = AVG_LOG2 + 1;

  logic [N_CH-1:0][ACC_W-1:0] r_acc;
  logic [FRM_W-1:0]           r_frm;

  // Only the last frame of each averaging window produces output words.
  assign w_out_frm = (r_frm == FRM_W'((1 << AVG_LOG2) - 1)) && !clear_i;
  assign w_word    = r_acc[w_ch][ACC_W-1:AVG_LOG2];

  // Accumulate each finished frame; restart the window after its output frame or on a flush.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_frm <= '0;
    end else if (clear_i) begin
      r_acc <= '0;
      r_frm <= '0;
    end else if (w_shift_done) begin
      for (int k = 0; k < N_CH; k++) r_acc[k] <= r_acc[k] + ACC_W'(r_sh[k]);
      r_frm <= r_frm + 1'b1;
    end else if (w_push_last && r_out_frm) begin
      r_acc <= '0;
      r_frm <= '0;
    end
  end
`else
  assign w_out_frm = 1'b1;
  assign w_word    = r_sh[w_ch];
`endif

  // Admission is decided once at PUSH entry so a frame is stored whole or not at all;
  // a flush while pushing discards the rest of the frame.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      r_drop    <= 1'b0;
      r_out_frm <= 1'b0;
    end else if (w_shift_done) begin
      r_out_frm <= w_out_frm;
      r_drop    <= !w_admit && !clear_i;
    end else if (r_state == S_PUSH && clear_i) begin
      r_drop    <= 1'b1;
    end
  end

  // Sticky overflow flag, cleared only by clear_i.
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (clear_i) r_ovf <= 1'b0;
    else if (w_shift_done && w_out_frm && !w_admit) r_ovf <= 1'b1;
  end

  assign w_wr = (r_state == S_PUSH) && r_out_frm && !r_drop && !clear_i;

  adc_acq_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_adc  (clk_adc),
    .rst_n    (rst_n),
    .i_clr    (clear_i),
    .i_wr_vld (w_wr),
    .i_wr_dat ({w_ch, w_word}),
    .i_rd_rdy (m_ready_i),
    .o_rd_dat (w_fifo_dat),
    .o_rd_vld (w_fifo_vld),
    .o_level  (w_level)
  );

  assign m_valid_o    = w_fifo_vld;
  assign m_data_o     = w_fifo_vld ? w_fifo_dat[DATA_WIDTH-1:0] : '0;
  assign m_ch_o       = w_fifo_vld ? w_fifo_dat[FW-1:DATA_WIDTH] : '0;
  assign fifo_level_o = w_level;
  assign overflow_o   = r_ovf;

endmodule
